// File: rtl/clip_round_pkg.sv
// Shared definitions for the clip/round pipeline: rounding-mode codes and
// the default saturation-counter width.
package clip_round_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_TRUNC = 2'd0;
  localparam mode_t MODE_AWAY  = 2'd1;
  localparam mode_t MODE_CONV  = 2'd2;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/clip_round_pipe_if.sv
// Sample stream bundle for clip_round_pipe: input beat with rounding mode,
// output beat with per-lane saturation flags, valid/ready on both sides.
interface clip_round_pipe_if #(
  parameter int BITS_IN  = 24,
  parameter int BITS_OUT = 16,
  parameter int CHANNELS = 2
);

  logic [CHANNELS*BITS_IN-1:0]  in_data;
  logic [1:0]                   in_mode;
  logic                         in_valid;
  logic                         in_ready;
  logic [CHANNELS*BITS_OUT-1:0] out_data;
  logic [CHANNELS-1:0]          out_sat;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );

endinterface

// File: rtl/clip_round_lane.sv
// One lane of the clip/round datapath. The rounding half feeds the stage-1
// register, the clipping half works on the registered rounded value.
module clip_round_lane
  import clip_round_pkg::*;
#(
  parameter int BITS_IN   = 24,
  parameter int BITS_OUT  = 16,
  parameter int CLIP_BITS = 4
) (
  input  logic signed [BITS_IN-1:0]         in_sample,
  input  mode_t                             mode,
  output logic signed [CLIP_BITS+BITS_OUT:0] r,
  input  logic signed [CLIP_BITS+BITS_OUT:0] r_q,
  output logic signed [BITS_OUT-1:0]        out_sample,
  output logic                              sat
);

  localparam int DROP     = BITS_IN - CLIP_BITS - BITS_OUT;
  // One bit wider than the kept field so a rounding carry cannot wrap.
  localparam int RW       = CLIP_BITS + BITS_OUT + 1;
  localparam int HALF_SH  = (DROP > 0) ? DROP - 1 : 0;
  localparam logic signed [BITS_IN:0] ONE  = {{BITS_IN{1'b0}}, 1'b1};
  localparam logic signed [BITS_IN:0] HALF = ONE <<< HALF_SH;
  localparam logic signed [RW-1:0] MAX_R = {{(RW-BITS_OUT+1){1'b0}}, {(BITS_OUT-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_R = {{(RW-BITS_OUT+1){1'b1}}, {(BITS_OUT-1){1'b0}}};

  function automatic logic signed [RW-1:0] round_shift(
    input logic signed [BITS_IN-1:0] x,
    input mode_t                     m
  );
    logic signed [BITS_IN:0] ext;
    logic signed [BITS_IN:0] bias;
    logic signed [BITS_IN:0] sum;
    ext  = {x[BITS_IN-1], x};
    bias = '0;
    if (DROP > 0) begin
      case (m)
        MODE_AWAY: bias = x[BITS_IN-1] ? HALF - ONE : HALF;
        // Ties go up only when the kept LSB is odd, landing on even.
        MODE_CONV: bias = HALF - ONE + {{BITS_IN{1'b0}}, x[DROP]};
        default:   bias = '0;
      endcase
    end
    sum = ext + bias;
    return sum[BITS_IN:DROP];
  endfunction

  function automatic logic [BITS_OUT:0] clip_sat(input logic signed [RW-1:0] v);
    if (v > MAX_R)
      return {1'b1, 1'b0, {(BITS_OUT-1){1'b1}}};
    else if (v < MIN_R)
      return {1'b1, 1'b1, {(BITS_OUT-1){1'b0}}};
    else
      return {1'b0, v[BITS_OUT-1:0]};
  endfunction

  // Round the incoming sample and drop its LSBs.
  always_comb r = round_shift(in_sample, mode);

  // Clip the registered rounded value into the output range.
  always_comb {sat, out_sample} = clip_sat(r_q);

endmodule

// File: rtl/clip_round_pipe.sv
// Two-stage multi-channel clip/round pipeline with valid/ready flow
// control and per-lane saturation counters.
module clip_round_pipe
  import clip_round_pkg::*;
#(
  parameter int BITS_IN   = 24,
  parameter int BITS_OUT  = 16,
  parameter int CLIP_BITS = 4,
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  clip_round_pipe_if.slave          bus,
  input  logic                      sat_clear,
  output logic [CHANNELS*CNT_W-1:0] sat_count
);

  localparam int RW = CLIP_BITS + BITS_OUT + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = (CNT_W)'(1);

  logic                         en;
  logic                         out_hs;
  logic                         vld_p1;
  logic                         vld_p2;
  logic [CHANNELS*RW-1:0]       r_c;
  logic [CHANNELS*RW-1:0]       r_p1;
  logic [CHANNELS*BITS_OUT-1:0] data_c;
  logic [CHANNELS-1:0]          sat_c;
  logic [CHANNELS*BITS_OUT-1:0] data_p2;
  logic [CHANNELS-1:0]          sat_p2;

  // A single enable moves both stages together, so a stall freezes everything.
  assign en           = ~vld_p2 | bus.out_ready;
  assign out_hs       = vld_p2 & bus.out_ready;
  assign bus.in_ready = en;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    clip_round_lane #(
      .BITS_IN   (BITS_IN),
      .BITS_OUT  (BITS_OUT),
      .CLIP_BITS (CLIP_BITS)
    ) u_lane (
      .in_sample  (bus.in_data[g*BITS_IN +: BITS_IN]),
      .mode       (bus.in_mode),
      .r          (r_c[g*RW +: RW]),
      .r_q        (r_p1[g*RW +: RW]),
      .out_sample (data_c[g*BITS_OUT +: BITS_OUT]),
      .sat        (sat_c[g])
    );
  end

  // ---- stage 1: rounded samples (mode already applied) ----
  // Capture rounded lanes; data only, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (en) r_p1 <= r_c;
  end

  // Stage valids advance with the common enable; reset discards in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 2: clipped output samples and saturation flags ----
  // Output register; flags of bubble slots are forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p2 <= '0;
      sat_p2  <= '0;
    end else if (en) begin
      data_p2 <= data_c;
      sat_p2  <= sat_c & {CHANNELS{vld_p1}};
    end
  end

  assign bus.out_data  = data_p2;
  assign bus.out_sat   = sat_p2;
  assign bus.out_valid = vld_p2;

  // Saturation counters: clear wins over hold, an increment in the same cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sat_clear)
          sat_count[i*CNT_W +: CNT_W] <= (out_hs && sat_p2[i]) ? CNT_ONE : '0;
        else if (out_hs && sat_p2[i] && (sat_count[i*CNT_W +: CNT_W] != '1))
          sat_count[i*CNT_W +: CNT_W] <= sat_count[i*CNT_W +: CNT_W] + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_clip_round_pipe.sv
// Directed bench for clip_round_pipe: rounding modes, saturation,
// backpressure, counters and asynchronous reset.
module tb_clip_round_pipe;
  import clip_round_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sat_clear = 1'b0;
  logic [31:0] sat_count;
  logic [7:0]  sat_count_s;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] got_data;
  logic [1:0]  got_sat;
  int          got_lat;

  clip_round_pipe_if #(.BITS_IN(24), .BITS_OUT(16), .CHANNELS(2)) bus ();
  clip_round_pipe_if #(.BITS_IN(24), .BITS_OUT(16), .CHANNELS(2)) bs ();

  assign bs.in_data   = bus.in_data;
  assign bs.in_mode   = bus.in_mode;
  assign bs.in_valid  = bus.in_valid;
  assign bs.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  clip_round_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .sat_clear (sat_clear),
    .sat_count (sat_count)
  );

  // Narrow-counter copy to reach the counter ceiling in a short run.
  clip_round_pipe #(.CNT_W(4)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bs.slave),
    .sat_clear (sat_clear),
    .sat_count (sat_count_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one beat, then wait (bounded) for it at the output.
  task automatic beat(input logic [23:0] a0, input logic [23:0] a1, input logic [1:0] m);
    int n;
    @(posedge clk); #1;
    bus.in_data  = {a1, a0};
    bus.in_mode  = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    got_lat  = n;
    got_data = bus.out_data;
    got_sat  = bus.out_sat;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
  endtask

  logic [23:0] v_in   [16];
  logic [1:0]  v_mode [16];
  logic [15:0] v_exp  [16];
  logic        v_sat  [16];
  logic [15:0] s_exp0 [8];
  logic [3:0]  rdy_pat;
  logic        m_v1, m_v2, m_en;
  int          tx, rx;

  initial begin
    v_in = '{24'h000018, 24'h000018, 24'h000018, 24'h000028, 24'h000028, 24'h000028,
             24'hFFFFE8, 24'hFFFFE8, 24'hFFFFE8, 24'hFFFFD8, 24'hFFFFD8, 24'hFFFFD8,
             24'h07FFF8, 24'h080000, 24'hF80000, 24'hF7FFFF};
    v_mode = '{MODE_TRUNC, MODE_AWAY, MODE_CONV, MODE_TRUNC, MODE_AWAY, MODE_CONV,
               MODE_TRUNC, MODE_AWAY, MODE_CONV, MODE_TRUNC, MODE_AWAY, MODE_CONV,
               MODE_AWAY, MODE_TRUNC, MODE_TRUNC, MODE_TRUNC};
    v_exp = '{16'h0001, 16'h0002, 16'h0002, 16'h0002, 16'h0003, 16'h0002,
              16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFD, 16'hFFFD, 16'hFFFE,
              16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
    v_sat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b0, 1'b1};
    s_exp0 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd8};
    rdy_pat = 4'b1001;

    bus.in_data   = '0;
    bus.in_mode   = MODE_TRUNC;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_sat_count", sat_count, 32'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    #10 rst_n = 1'b1;

    // Rounding modes and saturation on lane 0; lane 1 carries an exact value
    for (int i = 0; i < 16; i++) begin
      beat(v_in[i], 24'h000100, v_mode[i]);
      chk($sformatf("latency_%0d", i), got_lat, 2);
      chk($sformatf("round_data_%0d", i), got_data, {16'h0010, v_exp[i]});
      chk($sformatf("round_sat_%0d", i), got_sat, {1'b0, v_sat[i]});
    end
    @(posedge clk); #1;
    chk("cnt_after_vectors", sat_count, {16'd0, 16'd3});

    // Counters: 3 saturating beats on lane 1 only
    pulse_clear();
    chk("cnt_cleared", sat_count, 32'h0);
    for (int i = 0; i < 3; i++) begin
      beat(24'h000010, 24'h080000, MODE_TRUNC);
      chk($sformatf("lane1_data_%0d", i), got_data, {16'h7FFF, 16'h0001});
      chk($sformatf("lane1_sat_%0d", i), got_sat, 2'b10);
    end
    @(posedge clk); #1;
    chk("cnt_lane1_three", sat_count, {16'd3, 16'd0});

    // Clear coinciding with a saturating output handshake
    beat(24'h000000, 24'h080000, MODE_TRUNC);
    sat_clear = 1'b1;
    @(posedge clk); #1;
    sat_clear = 1'b0;
    chk("cnt_clear_and_count", sat_count, {16'd1, 16'd0});
    repeat (3) @(posedge clk);
    #1;

    // Backpressure stream with a mode change after beat 3
    tx = 0; rx = 0; m_v1 = 1'b0; m_v2 = 1'b0;
    for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
      bus.out_ready = rdy_pat[cyc % 4];
      bus.in_valid  = (tx < 8);
      bus.in_data   = {24'(tx * 16), 24'(tx * 16 + 8)};
      bus.in_mode   = (tx < 4) ? MODE_TRUNC : MODE_AWAY;
      @(negedge clk);
      m_en = ~m_v2 | bus.out_ready;
      chk($sformatf("bp_in_ready_%0d", cyc), bus.in_ready, m_en);
      chk($sformatf("bp_out_valid_%0d", cyc), bus.out_valid, m_v2);
      if (m_v2 && bus.out_ready) begin
        chk($sformatf("bp_data_%0d", rx), bus.out_data, {16'(rx), s_exp0[rx]});
        rx++;
      end
      if (bus.in_valid && m_en) tx++;
      if (m_en) begin
        m_v2 = m_v1;
        m_v1 = bus.in_valid;
      end
      @(posedge clk); #1;
    end
    chk("bp_all_received", rx, 8);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_no_dup_%0d", i), bus.out_valid, 1'b0);
    end
    chk("bp_cnt_untouched", sat_count, {16'd1, 16'd0});

    // Counter ceiling: 20 saturating beats on both lanes
    pulse_clear();
    bus.in_data  = {24'h080000, 24'h080000};
    bus.in_mode  = MODE_TRUNC;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("small_out_data", bs.out_data, 32'h7FFF7FFF);
    chk("small_out_sat", bs.out_sat, 2'b11);
    chk("small_in_ready", bs.in_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_twenty", sat_count, {16'd20, 16'd20});
    chk("cnt_small_ceiling", sat_count_s, 8'hFF);

    // Asynchronous reset with both stages full
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_data   = {24'h080000, 24'h080000};
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("full_before_reset", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_out_data", bus.out_data, 32'h0);
    chk("arst_out_sat", bus.out_sat, 2'b00);
    chk("arst_sat_count", sat_count, 32'h0);
    chk("arst_sat_count_small", sat_count_s, 8'h00);
    chk("arst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle_%0d", i), bus.out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clip_round_pipe.md
# clip_round_pipe

Pipelined, multi-channel successor to the combinational clip/round macro. It narrows CHANNELS packed two's-complement samples from BITS_IN to BITS_OUT bits. For each sample it discards CLIP_BITS guard MSBs and DROP = BITS_IN-CLIP_BITS-BITS_OUT LSBs, applies a run-time rounding mode, and saturates correctly even when rounding itself overflows. It sits between DSP accumulator outputs (CIC/halfband, DUC gain) and narrower sample buses. It provides a valid/ready handshake, per-beat saturation flags, and per-channel saturation counters for host readback.

## Interface
- BITS_IN, 24, input sample width.
- BITS_OUT, 16, output sample width.
- CLIP_BITS, 4, guard MSBs that must be pure sign extension.
- CHANNELS, 2, lanes processed in lockstep; must be ≥1.
- CNT_W, 16, saturation counter width.
- Constraint: DROP = BITS_IN-CLIP_BITS-BITS_OUT ≥ 0.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, reset, asynchronous and active-low.
- in_data, in, CHANNELS*BITS_IN, samples; channel 0 in LSBs.
- in_mode, in, 2, rounding mode for this beat: 00 truncate (floor), 01 round half away from zero, 10 convergent (half to even), 11 reserved (behaves as 00).
- in_valid, in, 1, beat offered.
- in_ready, out, 1, beat accepted when in_valid & in_ready.
- out_data, out, CHANNELS*BITS_OUT, result samples.
- out_sat, out, CHANNELS, per-lane flag: this beat was saturated.
- out_valid, out, 1, result present.
- out_ready, in, 1, downstream accepts.
- sat_clear, in, 1, synchronous clear of all counters.
- sat_count, out, CHANNELS*CNT_W, per-lane saturation counts; lane 0 in LSBs.

## Operation
- **Stage 1 (round).** Per lane, compute r = rounded(in >> DROP) at width BITS_IN-DROP+1. The extra bit absorbs rounding carry.
  - Truncate: r = in >>> DROP.
  - Half-away: add 2^(DROP-1) for non-negative input, or 2^(DROP-1)-1 for negative input, then shift.
  - Convergent: add 2^(DROP-1)-1 plus the LSB of the kept part, then shift.
  - DROP = 0: all modes pass through unchanged.
- **Stage 2 (clip).** If r > 2^(BITS_OUT-1)-1, output {0,1…1} and set sat. If r < -2^(BITS_OUT-1), output {1,0…0} and set sat. Otherwise output r[BITS_OUT-1:0] with sat = 0.
- **Mode sampling.** Mode is captured with the beat in stage 1. Changing in_mode never affects beats already in flight.
- **Counters.** Lane i's counter increments on each output handshake (out_valid & out_ready) with out_sat[i] = 1. Counters hold at all-ones and do not wrap.
- **Counter clear.** sat_clear zeroes all counters. If sat_clear coincides with an increment, the counter becomes 1 (clear, then count).
- **Reset.** Asynchronous assertion of rst_n zeroes out_data, out_sat, out_valid, the internal stage-1 valid, and all counters. In-flight beats are discarded. in_ready follows its combinational definition.

## Timing
- **Global enable.** en = ~out_valid | out_ready, and in_ready = en (combinational; no path from in_valid).
- **Advance.** When en = 1, stage 1 loads the input beat (valid = in_valid) and stage 2 loads stage 1.
- **Stall.** When en = 0, both stages hold, including out_data, out_sat and out_valid.
- **Latency.** 2 cycles from input handshake to out_valid, with out_ready held high.
- **Throughput.** 1 beat/cycle. Bubbles are not compressed.
- **Counter latency.** sat_count updates 1 cycle after the output handshake.

## Structure
- **Shared package/header `clip_round_pkg`.** Holds the mode constants MODE_TRUNC = 2'd0, MODE_AWAY = 2'd1, MODE_CONV = 2'd2, and the default CNT_W.
- **Sub-module `clip_round_lane`.** One lane's combinational round and clip, parametrised by BITS_IN, BITS_OUT and CLIP_BITS, with outputs r and sat split across the two register stages. It is instantiated CHANNELS times by generate.
- **Top level.** Owns the pipeline registers, the handshake logic and the counters.

## Test plan
All cases use default parameters (DROP = 4) and lane 0, unless stated.

1. **Rounding modes, positive ties.**
   - in = 0x000018: trunc → 0x0001; away → 0x0002; conv → 0x0002.
   - in = 0x000028: trunc → 0x0002; away → 0x0003; conv → 0x0002.
2. **Negative ties.**
   - in = 0xFFFFE8 (-1.5): all modes → 0xFFFE.
   - in = 0xFFFFD8 (-2.5): trunc → 0xFFFD; away → 0xFFFD; conv → 0xFFFE.
3. **Saturation, including rounding-induced overflow.**
   - 0x07FFF8 in away mode → 0x7FFF with sat = 1 (rounding carry).
   - 0x080000 → 0x7FFF, sat = 1.
   - 0xF80000 → 0x8000, sat = 0.
   - 0xF7FFFF in trunc mode → 0x8000, sat = 1.
4. **Backpressure.**
   - Stream 8 beats with out_ready toggling 1,0,0,1,…: no beat is lost or duplicated, outputs are in order, and in_ready equals ~out_valid | out_ready every cycle.
   - A mode change mid-stream applies only to subsequent beats.
5. **Counters.**
   - 3 saturating beats on lane 1 and 0 on lane 0 → sat_count = {16'd3, 16'd0}.
   - sat_clear coinciding with a saturating handshake → 1.
   - A counter preset near the top via a forced stream stops at 0xFFFF.
6. **Reset mid-operation.**
   - Drop rst_n asynchronously with both stages full: all outputs and counters read 0 immediately, and no stale beat appears after release.
